// File: rtl/qam16_rx_demapper.sv
// qam16_rx_demapper: decimate matched-filter I/Q to one sample per symbol, slice, demap to a nibble, 2-entry FIFO out.
// Define QAM16_RX_GRAY_EN for Gray demap; the default build uses natural-binary demap.
module qam16_rx_demapper #(
  parameter int SPS = 4,
  parameter int SAMPLE_PHASE = 0,
  parameter logic signed [15:0] THRESH = 16'sd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] din_i,
  input  logic signed [15:0] din_q,
  input  logic               din_valid,
  input  logic               align,
  output logic [3:0]         sym,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               overflow,
  output logic [15:0]        sym_count
);
  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] PH = CW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  function automatic logic [1:0] slice(input logic signed [15:0] v);
`ifdef QAM16_RX_GRAY_EN
    return v >= THRESH ? 2'b10 : v >= 16'sd0 ? 2'b11 : v >= -THRESH ? 2'b01 : 2'b00;
`else
    return v >= THRESH ? 2'b11 : v >= 16'sd0 ? 2'b10 : v >= -THRESH ? 2'b01 : 2'b00;
`endif
  endfunction

  logic [CW-1:0] cnt_q, cnt_d, eff;
  logic          dv_q;
  logic [3:0]    dsym_q;
  logic [3:0]    mem_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    fc_q;
  logic          overflow_q;
  logic [15:0]   sym_count_q;
  logic          dec, pop, push;

  // align overrides the running index for this cycle's sample
  always_comb begin
    eff = align ? '0 : cnt_q;
    dec = din_valid && eff == PH;
    cnt_d = !din_valid ? eff : eff == LAST ? '0 : eff + 1'b1;
    pop = fc_q != 2'd0 && sym_ready;
    push = dv_q && (fc_q != 2'd2 || pop);
  end

  assign sym = mem_q[rp_q];
  assign sym_valid = fc_q != 2'd0;
  assign overflow = overflow_q;
  assign sym_count = sym_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      dv_q <= 1'b0;
      dsym_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      fc_q <= '0;
      overflow_q <= 1'b0;
      sym_count_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dv_q <= dec;
      dsym_q <= {slice(din_i), slice(din_q)};
      if (push) begin
        mem_q[wp_q] <= dsym_q;
        wp_q <= !wp_q;
        sym_count_q <= sym_count_q + 1'b1;
      end
      if (pop) rp_q <= !rp_q;
      fc_q <= fc_q + {1'b0, push} - {1'b0, pop};
      if (dv_q && !push) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qam16_rx_demapper.sv
// tb_qam16_rx_demapper: randomized scoreboard bench for qam16_rx_demapper with directed scenarios.
module tb_qam16_rx_demapper;
  localparam int SPS = 4;
  localparam int PH = 2;
  localparam int T = 1024;
`ifdef QAM16_RX_GRAY_EN
  localparam logic [3:0] EXP1 = 4'b1001, EXP2 = 4'b1100, EXPA = 4'b1010, EXPR = 4'b1011;
`else
  localparam logic [3:0] EXP1 = 4'b1101, EXP2 = 4'b1000, EXPA = 4'b1111, EXPR = 4'b1110;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic signed [15:0] din_i, din_q;
  logic din_valid, align, sym_ready;
  logic [3:0] sym;
  logic sym_valid, overflow;
  logic [15:0] sym_count;

  qam16_rx_demapper #(.SPS(SPS), .SAMPLE_PHASE(PH), .THRESH(16'sd1024)) dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
    .align(align), .sym(sym), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .overflow(overflow), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [3:0] last_sym = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl(input int v);
    return v >= T ? 3 : v >= 0 ? 1 : v >= -T ? -1 : -3;
  endfunction

  function automatic logic [1:0] code(input int l);
    int k;
    k = (l + 3) / 2;
`ifdef QAM16_RX_GRAY_EN
    return 2'(k ^ (k >> 1));
`else
    return 2'(k);
`endif
  endfunction

  function automatic logic [3:0] ref_sym(input int i, input int q);
    return {code(lvl(i)), code(lvl(q))};
  endfunction

  // Reference: sample index modulo SPS, a one-edge decision delay, and a 2-deep queue.
  int idx = 0;
  bit pv = 0;
  logic [3:0] ps = '0;
  logic [3:0] expq[$];
  bit m_ovf = 0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk or negedge rst) begin
    int eff;
    bit pop;
    if (!rst) begin
      idx = 0;
      pv = 0;
      expq.delete();
      m_ovf = 0;
      m_cnt = '0;
    end else begin
      pop = expq.size() > 0 && sym_ready;
      if (pv) begin
        if (expq.size() < 2 || pop) begin
          expq.push_back(ps);
          m_cnt = m_cnt + 16'd1;
        end else m_ovf = 1;
      end
      if (pop) void'(expq.pop_front());
      eff = align ? 0 : idx;
      pv = din_valid && eff == PH;
      if (pv) ps = ref_sym(int'(din_i), int'(din_q));
      idx = din_valid ? (eff + 1) % SPS : eff;
    end
  end

  always @(negedge clk) begin
    chk("valid", {15'd0, sym_valid}, {15'd0, expq.size() != 0});
    chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
    chk("count", sym_count, m_cnt);
    if (sym_valid && sym_ready && expq.size() > 0) begin
      chk("sym", {12'd0, sym}, {12'd0, expq[0]});
      last_sym = sym;
    end
  end

  task automatic drive(input bit v, input int i, input int q, input bit al, input bit rd);
    @(posedge clk);
    #1;
    din_valid = v;
    din_i = 16'(i);
    din_q = 16'(q);
    align = al;
    sym_ready = rd;
  endtask

  function automatic int rv();
    case ($urandom_range(0, 6))
      0: return 1024;
      1: return 1023;
      2: return -1024;
      3: return -1025;
      4: return 0;
      5: return -1;
      default: return int'($signed(16'($urandom())));
    endcase
  endfunction

  initial begin
    din_valid = 0; din_i = '0; din_q = '0; align = 0; sym_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sym", {12'd0, sym}, 16'd0);
    chk("rst_valid", {15'd0, sym_valid}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    chk("rst_count", sym_count, 16'd0);
    rst = 1;
    drive(1, 3000, -500, 1, 1);
    repeat (19) drive(1, 3000, -500, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    chk("count20", sym_count, 16'd5);
    chk("sym_const", {12'd0, last_sym}, {12'd0, EXP1});
    repeat (4) drive(1, 1024, -1024, 0, 1);
    repeat (4) drive(1, 1023, -1025, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    chk("boundary", {12'd0, last_sym}, {12'd0, EXP2});
    repeat (2) drive(1, -3000, -3000, 0, 1);
    drive(1, -3000, -3000, 1, 1);
    drive(1, -3000, -3000, 0, 1);
    drive(1, 3000, 3000, 0, 1);
    repeat (2) drive(1, -3000, -3000, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    chk("align_sym", {12'd0, last_sym}, {12'd0, EXPA});
    chk("align_count", sym_count, 16'd8);
    for (int s = 0; s < 12; s++)
      drive(1, s < 4 ? 3000 : s < 8 ? -500 : -3000, 500, s == 0, s == 11);
    repeat (4) drive(0, 0, 0, 0, 1);
    chk("full_ovf", {15'd0, overflow}, 16'd0);
    chk("full_count", sym_count, 16'd11);
    for (int s = 0; s < 12; s++)
      drive(1, s < 4 ? 200 : s < 8 ? -2000 : 2000, -200, s == 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    chk("bp_ovf", {15'd0, overflow}, 16'd1);
    chk("bp_count", sym_count, 16'd13);
    repeat (4) drive(0, 0, 0, 0, 1);
    chk("bp_drained", {15'd0, sym_valid}, 16'd0);
    for (int s = 0; s < 6; s++) drive(1, 1500, -1500, s == 0, 0);
    #2;
    rst = 0;
    #1;
    chk("arst_valid", {15'd0, sym_valid}, 16'd0);
    chk("arst_ovf", {15'd0, overflow}, 16'd0);
    chk("arst_count", sym_count, 16'd0);
    repeat (2) drive(0, 0, 0, 0, 1);
    rst = 1;
    for (int k = 0; k < 8; k++) drive(1, (k == 2 || k == 6) ? 3000 : -3000, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    chk("post_rst_count", sym_count, 16'd2);
    chk("post_rst_sym", {12'd0, last_sym}, {12'd0, EXPR});
    repeat (3000)
      drive($urandom_range(0, 9) < 7, rv(), rv(), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    repeat (6) drive(0, 0, 0, 0, 1);
    chk("final_empty", {15'd0, sym_valid}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qam16_rx_demapper.md
# qam16_rx_demapper

Receive-side symbol recovery for the QAM16 datapath. Takes the 16-bit signed I/Q samples leaving the receive RRC matched filter at SPS samples per symbol, decimates them to one decision sample per symbol, slices each axis to the nearest of four levels, and demaps each symbol to a 4-bit nibble. It is the counterpart of the transmit mapper and RRC pulse shaper. Recovered nibbles are buffered in a 2-entry FIFO behind a valid/ready handshake.

## Interface
- SPS, 4: samples per symbol, 2..16.
- SAMPLE_PHASE, 0: sample index within a symbol used for the decision, 0..SPS-1.
- THRESH, 16'sd1024: decision threshold magnitude between the inner (±1) and outer (±3) levels.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- din_i  in  16  signed I sample from the matched filter.
- din_q  in  16  signed Q sample from the matched filter.
- din_valid  in  1  sample strobe; there is no backpressure to the filter.
- align  in  1  one-cycle pulse that forces the current cycle to be sample index 0.
- sym  out  4  recovered nibble {I[1:0], Q[1:0]}.
- sym_valid  out  1  FIFO not empty.
- sym_ready  in  1  consumer accepts `sym` when `sym_valid && sym_ready`.
- overflow  out  1  sticky; set when a decided symbol is dropped.
- sym_count  out  16  wrapping count of symbols pushed into the FIFO.

## Operation
- Sample counter `cnt`, 0..SPS-1:
  - Advances on each `din_valid` and wraps from SPS-1 to 0.
  - When `align` is high, that cycle's sample is index 0 and `cnt` becomes 1 if `din_valid` is high; it stays 0 if not.
- Decision event: `din_valid` high and the effective index equals SAMPLE_PHASE.
- Slicer, per axis with value v:
  - v >= THRESH gives +3.
  - 0 <= v < THRESH gives +1.
  - -THRESH <= v < 0 gives -1.
  - v < -THRESH gives -3.
  - Comparisons are signed and full-width; no saturation is needed.
- Demap, 2 bits per axis:
  - Gray: -3→00, -1→01, +1→11, +3→10.
  - Natural binary: -3→00, -1→01, +1→10, +3→11 (see Configuration).
- FIFO: 2 entries, with pointers plus a count.
  - Push happens on the registered decision.
  - Pop happens on `sym_valid && sym_ready`.
  - Push and pop in the same cycle when full: both succeed, the count stays 2, and `overflow` does not set.
  - Push while full with no pop: the symbol is dropped, `overflow` is set, and `sym_count` does not increment.
  - Pop while empty is ignored.
- `sym_count` increments on every successful push and wraps from 0xFFFF to 0.
- `overflow` is cleared only by reset.
- Reset (async assert, sync release): `cnt`=0, decision register empty, FIFO empty, `sym_valid`=0, `sym`=0, `overflow`=0, `sym_count`=0. Reset mid-symbol discards all partial state and any buffered symbols.

## Timing
- Decision sample accepted at edge N.
- Slice and demap are registered at N.
- FIFO push takes place at edge N+1.
- `sym_valid` and `sym` are visible after N+1, giving 2 cycles of latency from the input sample to the output.
- `sym` always shows the FIFO head and holds steady while `sym_valid && !sym_ready`.
- Maximum sustained rate is one symbol per SPS valid samples. With `sym_ready` held high, the FIFO never holds more than 1 entry.

## Configuration
- `QAM16_RX_GRAY_EN` defined: Gray demap as above. This must match the transmit mapper's Gray build.
- `QAM16_RX_GRAY_EN` not defined: natural-binary demap. Slicer, timing and all other behaviour are identical.

## Test plan
- Reset, then SPS=4, PHASE=0, continuous `din_valid`, I=+3000, Q=-500 on every sample, `sym_ready`=1 → one `sym` every 4 cycles. Expected value is 4'b1001 with Gray, or 4'b1101 without. `sym_count` reaches 5 after 20 samples.
- Boundary values with I=THRESH (1024) and Q=-1024 → I slices +3, Q slices -1. Then I=1023 and Q=-1025 → I slices +1, Q slices -3.
- Phase and align: PHASE=2, with a unique value on sample 2 only; pulse `align` mid-stream → the decision moves to the 3rd sample after `align`. `sym` reflects only the tagged samples.
- Backpressure: hold `sym_ready`=0 for 3 decision events → the first two symbols are held in order, the third is dropped, `overflow`=1 and `sym_count`=2. Releasing `sym_ready` drains exactly 2 symbols.
- Full FIFO with `sym_ready` asserted in the same cycle as a push → no drop, `overflow` stays 0, output order preserved.
- Assert `rst` low asynchronously mid-symbol with the FIFO holding 1 entry → `sym_valid`, `overflow`, `sym_count` and `cnt` clear immediately. The next decision occurs on effective index PHASE after release.
